// File: rtl/sata_link_pkg.sv
// rtl/sata_link_pkg.sv - shared link-layer constants, state encoding and scrambler keystream
//
// Purpose : primitive dwords, default LFSR seed, FSM state codes and the 32-bit
//           LFSR step used by both the RX descrambler and the TX scrambler.
// Ports   : none (package)
package sata_link_pkg;

    localparam logic [31:0] PRIM_SOF   = 32'h3737B57C;
    localparam logic [31:0] PRIM_EOF   = 32'hD5D5B57C;
    localparam logic [31:0] PRIM_HOLD  = 32'hD5D5AA7C;
    localparam logic [31:0] PRIM_HOLDA = 32'h9595AA7C;
    localparam logic [31:0] PRIM_CONT  = 32'h9999AA7C;
    localparam logic [31:0] PRIM_SYNC  = 32'hB5B5957C;
    localparam logic [31:0] PRIM_ALIGN = 32'h7B4A4ABC;

    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hFFFF;

    // x^16 + x^15 + x^13 + x^4 + 1, taps below x^16 as a Galois feedback mask
    localparam logic [15:0] LFSR_POLY = 16'hA011;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE       = 2'd0;
    localparam state_t ST_FRAME      = 2'd1;
    localparam state_t ST_FRAME_CONT = 2'd2;

    // Returns {next_lfsr[15:0], mask[31:0]}. Mask bit i is the LFSR MSB before
    // the i-th single-bit shift, so mask bit 0 is the first keystream bit.
    function automatic logic [47:0] lfsr_step32(input logic [15:0] lfsr);
        logic [15:0] s;
        logic [31:0] m;
        s = lfsr;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            m[i] = s[15];
            s    = {s[14:0], 1'b0} ^ (s[15] ? LFSR_POLY : 16'h0000);
        end
        return {s, m};
    endfunction

endpackage

// File: rtl/sata_lfsr32.sv
// rtl/sata_lfsr32.sv - combinational 32-bit LFSR advance and keystream mask
//
// Purpose : one full dword step of the link scrambler LFSR.
// Ports   : lfsr_cur  in  16  current LFSR state
//           lfsr_next out 16  state after 32 shifts
//           mask      out 32  keystream dword to XOR with data
module sata_lfsr32
    import sata_link_pkg::*;
(
    input  logic [15:0] lfsr_cur,
    output logic [15:0] lfsr_next,
    output logic [31:0] mask
);

    assign {lfsr_next, mask} = lfsr_step32(lfsr_cur);

endmodule

// File: rtl/rx_frame_descrambler.sv
// rtl/rx_frame_descrambler.sv - RX frame extractor, primitive stripper and descrambler
//
// Purpose : finds SOF/EOF in the aligned dword stream, drops flow-control and CONT
//           junk, descrambles payload and tags first/last (CRC) dwords.
// Ports   : clk, rst (sync active-high)
//           rx_valid/rx_data[31:0]/rx_isk   aligned receive dword stream
//           dout[31:0]/dout_valid/dout_sof/dout_eof   descrambled payload
//           frame_err   one-cycle error pulse
//           in_frame    high between accepted SOF and EOF/abort
module rx_frame_descrambler
    import sata_link_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED    = LFSR_SEED_DEFAULT,
    parameter int          MAX_FRAME_DW = 2050
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [31:0] rx_data,
    input  logic        rx_isk,
    output logic [31:0] dout,
    output logic        dout_valid,
    output logic        dout_sof,
    output logic        dout_eof,
    output logic        frame_err,
    output logic        in_frame
);

    localparam int CNT_W = $clog2(MAX_FRAME_DW + 1);

    state_t             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [31:0]        hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic               hold_first_q, hold_first_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        dout_q, dout_d;
    logic               dout_valid_q, dout_valid_d;
    logic               dout_sof_q, dout_sof_d;
    logic               dout_eof_q, dout_eof_d;
    logic               frame_err_q, frame_err_d;

    logic [15:0]        lfsr_next;
    logic [31:0]        lfsr_mask;
    logic               restart;

    sata_lfsr32 u_lfsr (
        .lfsr_cur  (lfsr_q),
        .lfsr_next (lfsr_next),
        .mask      (lfsr_mask)
    );

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        hold_first_d = hold_first_q;
        cnt_d        = cnt_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        dout_sof_d   = 1'b0;
        dout_eof_d   = 1'b0;
        frame_err_d  = 1'b0;
        restart      = 1'b0;

        if (rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_isk && rx_data == PRIM_SOF) begin
                        restart = 1'b1;
                    end
                end
                ST_FRAME, ST_FRAME_CONT: begin
                    if (!rx_isk) begin
                        // Under CONT, data dwords are repeat junk and never consume keystream.
                        if (state_q == ST_FRAME) begin
                            lfsr_d = lfsr_next;
                            if (cnt_q == CNT_W'(MAX_FRAME_DW)) begin
                                frame_err_d = 1'b1;
                                hold_full_d = 1'b0;
                                state_d     = ST_IDLE;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                                if (hold_full_q) begin
                                    dout_d       = hold_q;
                                    dout_valid_d = 1'b1;
                                    dout_sof_d   = hold_first_q;
                                end
                                hold_d       = rx_data ^ lfsr_mask;
                                hold_full_d  = 1'b1;
                                hold_first_d = !hold_full_q;
                            end
                        end
                    end else begin
                        state_d = ST_FRAME;
                        case (rx_data)
                            PRIM_SOF: begin
                                frame_err_d = 1'b1;
                                restart     = 1'b1;
                            end
                            PRIM_EOF: begin
                                // The dword still in hold is the CRC, so it carries eof.
                                if (hold_full_q) begin
                                    dout_d       = hold_q;
                                    dout_valid_d = 1'b1;
                                    dout_sof_d   = hold_first_q;
                                    dout_eof_d   = 1'b1;
                                end else begin
                                    frame_err_d = 1'b1;
                                end
                                hold_full_d = 1'b0;
                                state_d     = ST_IDLE;
                            end
                            PRIM_SYNC: begin
                                frame_err_d = 1'b1;
                                hold_full_d = 1'b0;
                                state_d     = ST_IDLE;
                            end
                            PRIM_CONT: begin
                                state_d = ST_FRAME_CONT;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                default: begin
                    hold_full_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            endcase
        end

        if (restart) begin
            state_d      = ST_FRAME;
            lfsr_d       = LFSR_SEED;
            cnt_d        = '0;
            hold_full_d  = 1'b0;
            hold_first_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            lfsr_q       <= LFSR_SEED;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            hold_first_q <= 1'b0;
            cnt_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_sof_q   <= 1'b0;
            dout_eof_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            hold_first_q <= hold_first_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_sof_q   <= dout_sof_d;
            dout_eof_q   <= dout_eof_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_sof   = dout_sof_q;
    assign dout_eof   = dout_eof_q;
    assign frame_err  = frame_err_q;
    assign in_frame   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rx_frame_descrambler.sv
// tb/tb_rx_frame_descrambler.sv - directed table-driven bench for rx_frame_descrambler
module tb_rx_frame_descrambler;

    localparam logic [31:0] P_SOF   = 32'h3737B57C;
    localparam logic [31:0] P_EOF   = 32'hD5D5B57C;
    localparam logic [31:0] P_HOLD  = 32'hD5D5AA7C;
    localparam logic [31:0] P_CONT  = 32'h9999AA7C;
    localparam logic [31:0] P_SYNC  = 32'hB5B5957C;
    localparam logic [31:0] P_ALIGN = 32'h7B4A4ABC;
    localparam logic [31:0] KS0     = 32'hC2D2768D;
    localparam logic [31:0] KS1     = 32'h1F26B368;
    localparam int          MAXDW   = 2050;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [31:0] rx_data = '0;
    logic        rx_isk = 1'b0;
    logic [31:0] dout;
    logic        dout_valid, dout_sof, dout_eof, frame_err, in_frame;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        vld;
        logic        isk;
        logic [31:0] data;
        logic [4:0]  flags;  // {valid, sof, eof, err, in_frame}
        logic [31:0] edout;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    rx_frame_descrambler dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_isk     (rx_isk),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_sof   (dout_sof),
        .dout_eof   (dout_eof),
        .frame_err  (frame_err),
        .in_frame   (in_frame)
    );

    function automatic void add(input logic vld, input logic isk, input logic [31:0] data,
                                input logic [4:0] flags, input logic [31:0] edout);
        vec_t v;
        v.vld = vld; v.isk = isk; v.data = data; v.flags = flags; v.edout = edout;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic vld, input logic isk, input logic [31:0] data);
        @(negedge clk);
        rx_valid = vld;
        rx_isk   = isk;
        rx_data  = data;
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string name, input logic [4:0] exp);
        logic [4:0] act;
        act = {dout_valid, dout_sof, dout_eof, frame_err, in_frame};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s flags{v,sof,eof,err,inf} got %b want %b", name, act, exp);
        end
    endtask

    task automatic check_dout(input string name, input logic [31:0] exp);
        checks++;
        if (dout !== exp) begin
            errors++;
            $display("FAIL %s dout got %h want %h", name, dout, exp);
        end
    endtask

    initial begin
        int n_valid, n_sof, n_eof, n_err;

        // flags: {valid, sof, eof, err, in_frame}
        // idle junk is ignored
        add(1, 0, 32'h00000000, 5'b00000, 0);
        add(1, 1, P_EOF,        5'b00000, 0);
        // case 1 with a stall between the data dwords
        add(1, 1, P_SOF,        5'b00001, 0);
        add(1, 0, KS0,          5'b00001, 0);
        add(0, 0, 32'hDEADBEEF, 5'b00001, 0);
        add(1, 0, KS1,          5'b11001, 32'h00000000);
        add(1, 1, P_EOF,        5'b10100, 32'h00000000);
        // case 2: primitives do not advance the LFSR
        add(1, 1, P_SOF,        5'b00001, 0);
        add(1, 0, KS0,          5'b00001, 0);
        add(1, 1, P_HOLD,       5'b00001, 0);
        add(1, 1, P_HOLD,       5'b00001, 0);
        add(1, 1, P_HOLD,       5'b00001, 0);
        add(1, 1, P_ALIGN,      5'b00001, 0);
        add(1, 0, KS1,          5'b11001, 32'h00000000);
        add(1, 1, P_EOF,        5'b10100, 32'h00000000);
        // case 3: CONT junk dropped
        add(1, 1, P_SOF,        5'b00001, 0);
        add(1, 0, KS0,          5'b00001, 0);
        add(1, 1, P_HOLD,       5'b00001, 0);
        add(1, 1, P_CONT,       5'b00001, 0);
        add(1, 0, 32'h12345678, 5'b00001, 0);
        add(1, 0, KS1,          5'b00001, 0);
        add(1, 0, 32'h00000000, 5'b00001, 0);
        add(1, 0, 32'hFFFFFFFF, 5'b00001, 0);
        add(1, 0, 32'hA5A5A5A5, 5'b00001, 0);
        add(1, 1, P_HOLD,       5'b00001, 0);
        add(1, 0, KS1,          5'b11001, 32'h00000000);
        add(1, 1, P_EOF,        5'b10100, 32'h00000000);
        // nonzero payload: 11111111 and A5A5A5A5 scrambled by hand
        add(1, 1, P_SOF,        5'b00001, 0);
        add(1, 0, 32'hD3C3679C, 5'b00001, 0);
        add(1, 0, 32'hBA8316CD, 5'b11001, 32'h11111111);
        add(1, 1, P_EOF,        5'b10100, 32'hA5A5A5A5);
        // case 4: SYNC abort then single-dword frame
        add(1, 1, P_SOF,        5'b00001, 0);
        add(1, 0, KS0,          5'b00001, 0);
        add(1, 1, P_SYNC,       5'b00010, 0);
        add(1, 1, P_SOF,        5'b00001, 0);
        add(1, 0, KS0,          5'b00001, 0);
        add(1, 1, P_EOF,        5'b11100, 32'h00000000);
        // case 5: empty frame, then SOF inside a frame
        add(1, 1, P_SOF,        5'b00001, 0);
        add(1, 1, P_EOF,        5'b00010, 0);
        add(1, 1, P_SOF,        5'b00001, 0);
        add(1, 0, KS0,          5'b00001, 0);
        add(1, 1, P_SOF,        5'b00011, 0);
        add(1, 0, KS0,          5'b00001, 0);
        add(1, 1, P_EOF,        5'b11100, 32'h00000000);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_flags("reset", 5'b00000);
        check_dout("reset", 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].vld, vecs[i].isk, vecs[i].data);
            check_flags($sformatf("vec%0d", i), vecs[i].flags);
            if (vecs[i].flags[4])
                check_dout($sformatf("vec%0d", i), vecs[i].edout);
        end

        // overflow: MAXDW+1 data dwords
        drive(1, 1, P_SOF);
        n_valid = 0; n_sof = 0; n_eof = 0; n_err = 0;
        for (int i = 1; i <= MAXDW; i++) begin
            drive(1, 0, 32'(i));
            n_valid += int'(dout_valid);
            n_sof   += int'(dout_sof);
            n_eof   += int'(dout_eof);
            n_err   += int'(frame_err);
        end
        checks++;
        if (n_valid != MAXDW - 1 || n_sof != 1 || n_eof != 0 || n_err != 0) begin
            errors++;
            $display("FAIL ovf_body counts v/sof/eof/err got %0d/%0d/%0d/%0d want %0d/1/0/0",
                     n_valid, n_sof, n_eof, n_err, MAXDW - 1);
        end
        check_flags("ovf_at_limit", 5'b10001);
        drive(1, 0, 32'h0BAD0BAD);
        check_flags("ovf_last", 5'b00010);
        drive(1, 1, P_EOF);
        check_flags("ovf_after", 5'b00000);

        // reset mid-frame
        drive(1, 1, P_SOF);
        drive(1, 0, KS0);
        drive(1, 0, KS1);
        check_flags("pre_rst", 5'b11001);
        @(negedge clk);
        rst = 1'b1;
        rx_valid = 1'b1;
        rx_isk = 1'b1;
        rx_data = P_EOF;
        @(posedge clk);
        #1;
        check_flags("mid_rst", 5'b00000);
        check_dout("mid_rst", 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 1, P_EOF);
        check_flags("post_rst_eof", 5'b00000);
        drive(0, 0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
